// File: rtl/mips_alu_mem_unit.sv
// ============================================================================
// Module   : mips_alu_mem_unit
// Brief    : Execute/memory slice of the single-cycle MIPS core: ALU control
//            decoder, 32-bit ALU and word-addressed data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_mem_unit #(
  parameter int MEM_WORDS = 256,
  parameter int MEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  output logic [3:0]  alu_ctrl,
  output logic        jump_reg,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic [31:0] mem_read_data
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_SRL  = 4'b0100;
  localparam logic [3:0] C_SRA  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_XOR  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_LUI  = 4'b1010;
  localparam logic [3:0] C_NOR  = 4'b1100;

  logic [31:0]       r_mem [MEM_WORDS];
  logic [MEM_AW-1:0] w_index;

  always_comb begin
    alu_ctrl = C_ADD;
    jump_reg = 1'b0;
    case (alu_op)
      3'b000: alu_ctrl = C_ADD;
      3'b001: alu_ctrl = C_SUB;
      3'b011: alu_ctrl = C_AND;
      3'b100: alu_ctrl = C_OR;
      3'b101: alu_ctrl = C_SLT;
      3'b110: alu_ctrl = C_XOR;
      3'b111: alu_ctrl = C_LUI;
      default: begin
        case (funct)
          6'b100000, 6'b100001: alu_ctrl = C_ADD;
          6'b100010, 6'b100011: alu_ctrl = C_SUB;
          6'b100100:            alu_ctrl = C_AND;
          6'b100101:            alu_ctrl = C_OR;
          6'b100110:            alu_ctrl = C_XOR;
          6'b100111:            alu_ctrl = C_NOR;
          6'b101010:            alu_ctrl = C_SLT;
          6'b101011:            alu_ctrl = C_SLTU;
          6'b000000:            alu_ctrl = C_SLL;
          6'b000010:            alu_ctrl = C_SRL;
          6'b000011:            alu_ctrl = C_SRA;
          6'b001000: begin
            alu_ctrl = C_ADD;
            jump_reg = 1'b1;
          end
          default:              alu_ctrl = C_ADD;
        endcase
      end
    endcase
  end

  // Shifts operate on B by shamt; A is ignored for them.
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctrl)
      C_ADD:  alu_result = operand_a + operand_b;
      C_SUB:  alu_result = operand_a - operand_b;
      C_AND:  alu_result = operand_a & operand_b;
      C_OR:   alu_result = operand_a | operand_b;
      C_XOR:  alu_result = operand_a ^ operand_b;
      C_NOR:  alu_result = ~(operand_a | operand_b);
      C_SLT:  alu_result = {31'h0, $signed(operand_a) < $signed(operand_b)};
      C_SLTU: alu_result = {31'h0, operand_a < operand_b};
      C_SLL:  alu_result = operand_b << shamt;
      C_SRL:  alu_result = operand_b >> shamt;
      C_SRA:  alu_result = $signed(operand_b) >>> shamt;
      C_LUI:  alu_result = {operand_b[15:0], 16'h0000};
      default: alu_result = 32'h0;
    endcase
  end

  assign alu_zero = (alu_result == 32'h0);
  assign w_index  = alu_result[MEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (mem_write) begin
      r_mem[w_index] <= store_data;
    end
  end

  assign mem_read_data = (mem_read && !rst) ? r_mem[w_index] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_mem_unit.sv
// ============================================================================
// Module   : tb_mips_alu_mem_unit
// Brief    : Directed self-checking bench for mips_alu_mem_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu_mem_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] store_data;
  logic [3:0]  alu_ctrl;
  logic        jump_reg;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_pass   = 0;

  mips_alu_mem_unit #(.MEM_WORDS(256), .MEM_AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op       (alu_op),
    .funct        (funct),
    .shamt        (shamt),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .store_data   (store_data),
    .alu_ctrl     (alu_ctrl),
    .jump_reg     (jump_reg),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct = f; shamt = sh; operand_a = a; operand_b = b;
    #1;
  endtask

  // Applies one write edge, then returns 1 time unit after it with writes off.
  task automatic store(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    set_alu(3'b000, 6'h00, 5'd0, a, b);
    store_data = d;
    mem_write  = 1'b1;
    @(posedge clk); #1;
    mem_write  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_op = 3'b000; funct = 6'h00; shamt = 5'd0;
    operand_a = 32'h0; operand_b = 32'h0;
    mem_read = 1'b1; mem_write = 1'b0; store_data = 32'h0;
    #12;
    check("reset_rdata", mem_read_data, 32'h0);
    check("reset_zero", {31'h0, alu_zero}, 32'h1);
    rst = 1'b0;
    #1;
    check("post_reset_mem0", mem_read_data, 32'h0);

    // R-type SUB equal operands
    set_alu(3'b010, 6'b100010, 5'd0, 32'd5, 32'd5);
    check("sub_ctrl", {28'h0, alu_ctrl}, 32'h6);
    check("sub_result", alu_result, 32'h0);
    check("sub_zero", {31'h0, alu_zero}, 32'h1);
    check("sub_jr", {31'h0, jump_reg}, 32'h0);

    // Signed vs unsigned compare
    set_alu(3'b010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1);
    check("slt", alu_result, 32'h1);
    check("slt_zero", {31'h0, alu_zero}, 32'h0);
    set_alu(3'b010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'd1);
    check("sltu", alu_result, 32'h0);
    check("sltu_ctrl", {28'h0, alu_ctrl}, 32'h9);

    // Shifts ignore A
    set_alu(3'b010, 6'b000000, 5'd4, 32'h12345678, 32'h80000010);
    check("sll", alu_result, 32'h00000100);
    set_alu(3'b010, 6'b000010, 5'd4, 32'h12345678, 32'h80000010);
    check("srl", alu_result, 32'h08000001);
    set_alu(3'b010, 6'b000011, 5'd4, 32'h12345678, 32'h80000010);
    check("sra", alu_result, 32'hF8000001);

    // Bitwise and misc
    set_alu(3'b010, 6'b100111, 5'd0, 32'hF0F0F0F0, 32'h0000FFFF);
    check("nor", alu_result, 32'h0F0F0000);
    set_alu(3'b110, 6'h3F, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
    check("xor_op", alu_result, 32'hF0F0F0F0);
    set_alu(3'b011, 6'h00, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
    check("and_op", alu_result, 32'h0F000F00);
    set_alu(3'b100, 6'h00, 5'd0, 32'hFF000000, 32'h000000FF);
    check("or_op", alu_result, 32'hFF0000FF);
    set_alu(3'b111, 6'h00, 5'd0, 32'hDEAD0000, 32'hFFFF1234);
    check("lui", alu_result, 32'h12340000);
    set_alu(3'b001, 6'h00, 5'd0, 32'd3, 32'd5);
    check("sub_wrap", alu_result, 32'hFFFFFFFE);
    set_alu(3'b000, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd2);
    check("add_wrap", alu_result, 32'h1);
    set_alu(3'b101, 6'h00, 5'd0, 32'd7, 32'h80000000);
    check("slt_op_neg", alu_result, 32'h0);
    set_alu(3'b010, 6'b111111, 5'd0, 32'd10, 32'd20);
    check("unknown_funct_add", alu_result, 32'd30);
    check("unknown_funct_ctrl", {28'h0, alu_ctrl}, 32'h2);

    // JR
    set_alu(3'b010, 6'b001000, 5'd0, 32'h400, 32'h0);
    check("jr_flag", {31'h0, jump_reg}, 32'h1);
    check("jr_ctrl", {28'h0, alu_ctrl}, 32'h2);
    set_alu(3'b000, 6'b001000, 5'd0, 32'h400, 32'h0);
    check("jr_not_rtype", {31'h0, jump_reg}, 32'h0);

    // Store / load with address aliasing
    store(32'h100, 32'd8, 32'hDEADBEEF);
    set_alu(3'b000, 6'h00, 5'd0, 32'h100, 32'd8);
    check("load", mem_read_data, 32'hDEADBEEF);
    set_alu(3'b000, 6'h00, 5'd0, 32'h100, 32'h0B);
    check("load_unaligned", mem_read_data, 32'hDEADBEEF);
    set_alu(3'b000, 6'h00, 5'd0, 32'h500, 32'd8);
    check("load_alias", mem_read_data, 32'hDEADBEEF);
    set_alu(3'b000, 6'h00, 5'd0, 32'h100, 32'd12);
    check("load_neighbour", mem_read_data, 32'h0);

    // Same-cycle read/write: old data before edge, new after
    set_alu(3'b000, 6'h00, 5'd0, 32'h100, 32'd8);
    store_data = 32'hCAFEF00D;
    mem_write  = 1'b1;
    #1;
    check("rw_before_edge", mem_read_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    mem_write = 1'b0;
    check("rw_after_edge", mem_read_data, 32'hCAFEF00D);

    // Reset clears memory
    store(32'h0, 32'h0, 32'h12345678);
    set_alu(3'b000, 6'h00, 5'd0, 32'h0, 32'h0);
    check("mem0_written", mem_read_data, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    check("rdata_in_reset", mem_read_data, 32'h0);
    rst = 1'b0;
    #1;
    check("mem0_cleared", mem_read_data, 32'h0);
    set_alu(3'b000, 6'h00, 5'd0, 32'h100, 32'd8);
    check("word66_cleared", mem_read_data, 32'h0);

    // Write held across an edge while in reset must not land
    set_alu(3'b000, 6'h00, 5'd0, 32'h0, 32'h0);
    store_data = 32'hFFFFFFFF;
    mem_write  = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    set_alu(3'b000, 6'h00, 5'd0, 32'h30, 32'h4);
    check("alu_in_reset", alu_result, 32'h34);
    mem_write = 1'b0;
    #1;
    rst = 1'b0;
    set_alu(3'b000, 6'h00, 5'd0, 32'h0, 32'h0);
    check("write_blocked", mem_read_data, 32'h0);

    // mem_read low forces zero output
    store(32'h0, 32'h0, 32'hA5A5A5A5);
    check("mem0_rewritten", mem_read_data, 32'hA5A5A5A5);
    mem_read = 1'b0;
    #1;
    check("no_read_zero", mem_read_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
